hit_responder: RTL and testbench

Responder end of the gg_fpga trigger/hit interface. It accepts trigger requests from the trigger engine and answers each with a hit pulse. The pulse is raised either automatically (AUTO_HIT_WIDTH) or on a debounced player button (MANUAL). In BOUNCE_BACK mode it returns a one-cycle acknowledge to the initiator. It sits between the trigger engine and the hit scoring/output logic, and keeps saturating hit and miss statistics.

---
 rtl/gg_fpga_pkg.sv | 22 ++
 rtl/hit_responder_btn_debounce.sv | 50 +++++
 rtl/hit_responder.sv | 147 ++++++++++++++
 tb/tb_hit_responder.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gg_fpga_pkg.sv
// rtl/gg_fpga_pkg.sv - gg_fpga shared trigger/hit interface types
package gg_fpga_pkg;

    typedef enum logic {
        STATIC      = 1'b0,
        BOUNCE_BACK = 1'b1
    } trigger_mode_t;

    // Encodings 2 and 3 are unassigned and behave as MANUAL.
    typedef enum logic [1:0] {
        MANUAL         = 2'd0,
        AUTO_HIT_WIDTH = 2'd1
    } hitting_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HIT   = 2'd2,
        ACK   = 2'd3
    } hit_resp_state_t;

endpackage

// File: rtl/hit_responder_btn_debounce.sv
// rtl/hit_responder_btn_debounce.sv - button synchronizer and stable-sample debouncer
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any sample agreeing with the current level restarts the run.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_level = level_q;

endmodule

// File: rtl/hit_responder.sv
// rtl/hit_responder.sv - trigger responder raising auto or button-driven hit pulses
module hit_responder
    import gg_fpga_pkg::*;
#(
    parameter int HIT_WIDTH_W     = 8,
    parameter int TIMEOUT_W       = 16,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  trigger_mode_t          trigger_mode,
    input  hitting_mode_t          hitting_mode,
    input  logic                   trig_valid,
    output logic                   trig_ready,
    input  logic [HIT_WIDTH_W-1:0] hit_width_cfg,
    input  logic [TIMEOUT_W-1:0]   timeout_cfg,
    input  logic                   manual_btn,
    input  logic                   counts_clr,
    output logic                   hit_out,
    output logic                   bounce_ack,
    output logic                   busy,
    output logic [CNT_W-1:0]       hit_count,
    output logic [CNT_W-1:0]       miss_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    hit_resp_state_t        state_q, state_d;
    logic                   bounce_q, bounce_d;
    logic                   auto_q, auto_d;
    logic [HIT_WIDTH_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [TIMEOUT_W-1:0]   timer_q, timer_d;
    logic                   hit_out_q, hit_out_d;
    logic                   bounce_ack_q, bounce_ack_d;
    logic [CNT_W-1:0]       hit_count_q, hit_count_d;
    logic [CNT_W-1:0]       miss_count_q, miss_count_d;
    logic                   btn_prev_q, btn_prev_d;
    logic                   btn_level;
    logic                   btn_rise;
    logic                   hit_inc;
    logic                   miss_inc;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (manual_btn),
        .btn_level(btn_level)
    );

    assign btn_rise = btn_level && !btn_prev_q;

    always_comb begin
        state_d    = state_q;
        bounce_d   = bounce_q;
        auto_d     = auto_q;
        hit_cnt_d  = hit_cnt_q;
        timer_d    = timer_q;
        btn_prev_d = btn_level;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;

        case (state_q)
            IDLE: begin
                if (trig_valid) begin
                    state_d   = ARMED;
                    bounce_d  = (trigger_mode == BOUNCE_BACK);
                    auto_d    = (hitting_mode == AUTO_HIT_WIDTH);
                    hit_cnt_d = (hit_width_cfg == '0) ? '0 : hit_width_cfg - 1'b1;
                    timer_d   = timeout_cfg;
                end
            end
            ARMED: begin
                // A press on the expiry cycle wins; a zero timer never expires.
                if (auto_q || btn_rise) begin
                    state_d = HIT;
                end else if (timer_q == TIMEOUT_W'(1)) begin
                    state_d  = IDLE;
                    miss_inc = 1'b1;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end
            end
            HIT: begin
                if (hit_cnt_q == '0) begin
                    hit_inc = 1'b1;
                    state_d = bounce_q ? ACK : IDLE;
                end else begin
                    hit_cnt_d = hit_cnt_q - 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        hit_out_d    = (state_d == HIT);
        bounce_ack_d = (state_d == ACK);

        if (counts_clr) begin
            hit_count_d  = '0;
            miss_count_d = '0;
        end else begin
            hit_count_d  = (hit_inc && hit_count_q != CNT_MAX) ? hit_count_q + 1'b1 : hit_count_q;
            miss_count_d = (miss_inc && miss_count_q != CNT_MAX) ? miss_count_q + 1'b1 : miss_count_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bounce_q     <= 1'b0;
            auto_q       <= 1'b0;
            hit_cnt_q    <= '0;
            timer_q      <= '0;
            hit_out_q    <= 1'b0;
            bounce_ack_q <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            btn_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bounce_q     <= bounce_d;
            auto_q       <= auto_d;
            hit_cnt_q    <= hit_cnt_d;
            timer_q      <= timer_d;
            hit_out_q    <= hit_out_d;
            bounce_ack_q <= bounce_ack_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            btn_prev_q   <= btn_prev_d;
        end
    end

    assign trig_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign hit_out    = hit_out_q;
    assign bounce_ack = bounce_ack_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_hit_responder.sv
// tb/tb_hit_responder.sv - randomized self-checking bench for hit_responder
module tb_hit_responder;
    import gg_fpga_pkg::*;

    localparam int MAXC = 1200;
    localparam int DB   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    trigger_mode_t trigger_mode = STATIC;
    hitting_mode_t hitting_mode = MANUAL;
    logic          trig_valid = 1'b0;
    logic [7:0]    hit_width_cfg = 8'd1;
    logic [15:0]   timeout_cfg = 16'd1;
    logic          manual_btn = 1'b0;
    logic          counts_clr = 1'b0;
    logic          trig_ready, hit_out, bounce_ack, busy;
    logic [15:0]   hit_count, miss_count;
    logic          s_trig_ready, s_hit_out, s_bounce_ack, s_busy;
    logic [3:0]    s_hit_count, s_miss_count;

    always #5 clk = ~clk;

    hit_responder u_dut (
        .clk(clk), .rst_n(rst_n), .trigger_mode(trigger_mode), .hitting_mode(hitting_mode),
        .trig_valid(trig_valid), .trig_ready(trig_ready), .hit_width_cfg(hit_width_cfg),
        .timeout_cfg(timeout_cfg), .manual_btn(manual_btn), .counts_clr(counts_clr),
        .hit_out(hit_out), .bounce_ack(bounce_ack), .busy(busy),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    hit_responder #(.CNT_W(4)) u_small (
        .clk(clk), .rst_n(rst_n), .trigger_mode(trigger_mode), .hitting_mode(hitting_mode),
        .trig_valid(trig_valid), .trig_ready(s_trig_ready), .hit_width_cfg(hit_width_cfg),
        .timeout_cfg(timeout_cfg), .manual_btn(manual_btn), .counts_clr(counts_clr),
        .hit_out(s_hit_out), .bounce_ack(s_bounce_ack), .busy(s_busy),
        .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    logic          vld_a [MAXC];
    logic          raw_a [MAXC];
    logic          clr_a [MAXC];
    trigger_mode_t tm_a  [MAXC];
    hitting_mode_t hm_a  [MAXC];
    logic [7:0]    w_a   [MAXC];
    logic [15:0]   to_a  [MAXC];
    logic [3:0]    obs_a [MAXC];
    logic [3:0]    exp_a [MAXC];
    logic          lev   [MAXC+1];
    logic          inc_h [MAXC];
    logic          inc_m [MAXC];
    int            exp_hits = 0;
    int            exp_miss = 0;
    int            total = 0;
    int            bad = 0;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic setup(input int n, input trigger_mode_t tm, input hitting_mode_t hm,
                         input int w, input int t);
        for (int k = 0; k < n; k++) begin
            vld_a[k] = 1'b0; raw_a[k] = 1'b0; clr_a[k] = 1'b0;
            tm_a[k] = tm; hm_a[k] = hm; w_a[k] = 8'(w); to_a[k] = 16'(t);
        end
    endtask

    task automatic gen_random(input int n);
        int k;
        int len;
        logic val;
        for (int j = 0; j < n; j++) begin
            vld_a[j] = (j < n - 60) && ($urandom_range(2) == 0);
            tm_a[j]  = trigger_mode_t'(1'($urandom_range(1)));
            hm_a[j]  = hitting_mode_t'(2'($urandom_range(3)));
            w_a[j]   = 8'($urandom_range(5));
            to_a[j]  = 16'($urandom_range(15, 1));
            clr_a[j] = ($urandom_range(39) == 0);
            raw_a[j] = 1'b0;
        end
        k = 0; val = 1'b0;
        while (k < n - 60) begin
            len = $urandom_range(8, 1);
            for (int j = 0; j < len && k < n - 60; j++) begin
                raw_a[k] = val;
                k++;
            end
            val = !val;
        end
    endtask

    // Timeline model: debounced level from run lengths, then one busy interval per accept.
    task automatic predict(input int n);
        int  lvl, run, s, c, a, hs, wid, lim;
        bit  auto_m, bb, found;
        lvl = 0; run = 0; lev[0] = 1'b0;
        for (int k = 0; k < n; k++) begin
            s = (k >= 2) ? int'(raw_a[k-2]) : 0;
            if (s != lvl) begin
                run++;
                if (run == DB) begin lvl = s; run = 0; end
            end else run = 0;
            lev[k+1] = (lvl != 0);
            exp_a[k] = 4'b1000; inc_h[k] = 1'b0; inc_m[k] = 1'b0;
        end
        c = 0;
        while (c < n) begin
            if (!vld_a[c]) begin c++; continue; end
            a = c;
            auto_m = (hm_a[a] == AUTO_HIT_WIDTH);
            bb     = (tm_a[a] == BOUNCE_BACK);
            wid    = (w_a[a] == 8'd0) ? 1 : int'(w_a[a]);
            found  = auto_m; hs = a + 2;
            lim    = (to_a[a] == 16'd0) ? n - 1 : a + int'(to_a[a]);
            if (!auto_m) begin
                for (int cc = a + 1; cc <= lim && cc < n; cc++) begin
                    if (lev[cc] && !lev[cc-1]) begin found = 1'b1; hs = cc + 1; break; end
                end
            end
            if (!found) begin
                for (int k = a + 1; k <= lim && k < n; k++) exp_a[k] = 4'b0100;
                if (to_a[a] != 16'd0 && lim < n) inc_m[lim] = 1'b1;
                c = lim + 1;
                continue;
            end
            for (int k = a + 1; k < hs && k < n; k++) exp_a[k] = 4'b0100;
            for (int k = hs; k < hs + wid && k < n; k++) exp_a[k] = 4'b0110;
            if (hs + wid - 1 < n) inc_h[hs + wid - 1] = 1'b1;
            c = hs + wid;
            if (bb) begin
                if (c < n) exp_a[c] = 4'b0101;
                c++;
            end
        end
        for (int k = 0; k < n; k++) begin
            if (clr_a[k]) begin exp_hits = 0; exp_miss = 0; end
            else begin exp_hits += int'(inc_h[k]); exp_miss += int'(inc_m[k]); end
        end
    endtask

    task automatic run_trial(input int n);
        predict(n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            obs_a[c] = {trig_ready, busy, hit_out, bounce_ack};
            trig_valid = vld_a[c]; trigger_mode = tm_a[c]; hitting_mode = hm_a[c];
            hit_width_cfg = w_a[c]; timeout_cfg = to_a[c];
            manual_btn = raw_a[c]; counts_clr = clr_a[c];
        end
        @(posedge clk); #1;
        trig_valid = 1'b0; manual_btn = 1'b0; counts_clr = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk) rst_n = 1'b0;
        trig_valid = 1'b0; manual_btn = 1'b0; counts_clr = 1'b0;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        exp_hits = 0; exp_miss = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (trig_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", trig_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if ({trig_ready, busy, hit_out, bounce_ack} !== 4'b1000) begin
            bad++; $display("FAIL reset_outputs got=%b exp=1000", {trig_ready, busy, hit_out, bounce_ack}); end
        total++; if (hit_count !== 16'd0) begin bad++; $display("FAIL reset_hit_count got=%0d exp=0", hit_count); end
        total++; if (miss_count !== 16'd0) begin bad++; $display("FAIL reset_miss_count got=%0d exp=0", miss_count); end
    endtask

    task automatic test_auto();
        setup(30, STATIC, AUTO_HIT_WIDTH, 3, 0);
        vld_a[2] = 1'b1;
        run_trial(30);
        for (int c = 0; c < 30; c++) begin
            total++;
            if (obs_a[c] !== exp_a[c]) begin bad++; $display("FAIL auto_static cyc=%0d got=%b exp=%b", c, obs_a[c], exp_a[c]); end
        end
        total++; if (hit_count !== 16'(sat(exp_hits, 65535))) begin
            bad++; $display("FAIL auto_static_count got=%0d exp=%0d", hit_count, exp_hits); end
        setup(30, BOUNCE_BACK, AUTO_HIT_WIDTH, 0, 0);
        vld_a[3] = 1'b1;
        run_trial(30);
        for (int c = 0; c < 30; c++) begin
            total++;
            if (obs_a[c] !== exp_a[c]) begin bad++; $display("FAIL auto_bounce cyc=%0d got=%b exp=%b", c, obs_a[c], exp_a[c]); end
        end
        total++; if (hit_count !== 16'(sat(exp_hits, 65535))) begin
            bad++; $display("FAIL auto_bounce_count got=%0d exp=%0d", hit_count, exp_hits); end
    endtask

    task automatic test_manual();
        setup(40, STATIC, MANUAL, 2, 20);
        vld_a[2] = 1'b1;
        for (int k = 7; k < 17; k++) raw_a[k] = 1'b1;
        run_trial(40);
        for (int c = 0; c < 40; c++) begin
            total++;
            if (obs_a[c] !== exp_a[c]) begin bad++; $display("FAIL manual_press cyc=%0d got=%b exp=%b", c, obs_a[c], exp_a[c]); end
        end
        total++; if (miss_count !== 16'(sat(exp_miss, 65535))) begin
            bad++; $display("FAIL manual_press_miss got=%0d exp=%0d", miss_count, exp_miss); end
    endtask

    task automatic test_timeout();
        setup(30, BOUNCE_BACK, hitting_mode_t'(2'd2), 1, 10);
        vld_a[2] = 1'b1;
        run_trial(30);
        for (int c = 0; c < 30; c++) begin
            total++;
            if (obs_a[c] !== exp_a[c]) begin bad++; $display("FAIL timeout10 cyc=%0d got=%b exp=%b", c, obs_a[c], exp_a[c]); end
        end
        total++; if (miss_count !== 16'(sat(exp_miss, 65535))) begin
            bad++; $display("FAIL timeout10_miss got=%0d exp=%0d", miss_count, exp_miss); end
        setup(1010, STATIC, MANUAL, 1, 0);
        vld_a[2] = 1'b1;
        run_trial(1010);
        for (int c = 0; c < 1010; c++) begin
            total++;
            if (obs_a[c] !== exp_a[c]) begin bad++; $display("FAIL no_timeout cyc=%0d got=%b exp=%b", c, obs_a[c], exp_a[c]); end
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL no_timeout_still_armed got=%b exp=1", busy); end
        total++; if (miss_count !== 16'(sat(exp_miss, 65535))) begin
            bad++; $display("FAIL no_timeout_miss got=%0d exp=%0d", miss_count, exp_miss); end
        apply_reset();
    endtask

    task automatic test_glitch_and_held();
        setup(60, STATIC, MANUAL, 1, 100);
        vld_a[2] = 1'b1;
        raw_a[6] = 1'b1; raw_a[7] = 1'b1; raw_a[9] = 1'b1; raw_a[10] = 1'b1;
        for (int k = 20; k < 26; k++) raw_a[k] = 1'b1;
        run_trial(60);
        for (int c = 0; c < 60; c++) begin
            total++;
            if (obs_a[c] !== exp_a[c]) begin bad++; $display("FAIL glitch cyc=%0d got=%b exp=%b", c, obs_a[c], exp_a[c]); end
        end
        setup(80, BOUNCE_BACK, MANUAL, 3, 60);
        vld_a[12] = 1'b1;
        for (int k = 0; k < 20; k++) raw_a[k] = 1'b1;
        for (int k = 30; k < 38; k++) raw_a[k] = 1'b1;
        run_trial(80);
        for (int c = 0; c < 80; c++) begin
            total++;
            if (obs_a[c] !== exp_a[c]) begin bad++; $display("FAIL held_btn cyc=%0d got=%b exp=%b", c, obs_a[c], exp_a[c]); end
        end
        total++; if (hit_count !== 16'(sat(exp_hits, 65535))) begin
            bad++; $display("FAIL held_btn_count got=%0d exp=%0d", hit_count, exp_hits); end
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 2; t++) begin
            setup(120, trigger_mode_t'(1'(t)), AUTO_HIT_WIDTH, $urandom_range(4), 0);
            for (int k = 0; k < 60; k++) vld_a[k] = 1'b1;
            run_trial(120);
            for (int c = 0; c < 120; c++) begin
                total++;
                if (obs_a[c] !== exp_a[c]) begin bad++; $display("FAIL back_to_back t=%0d cyc=%0d got=%b exp=%b", t, c, obs_a[c], exp_a[c]); end
            end
        end
        total++; if (hit_count !== 16'(sat(exp_hits, 65535))) begin
            bad++; $display("FAIL back_to_back_count got=%0d exp=%0d", hit_count, exp_hits); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            gen_random(200);
            run_trial(200);
            for (int c = 0; c < 200; c++) begin
                total++;
                if (obs_a[c] !== exp_a[c]) begin bad++; $display("FAIL random t=%0d cyc=%0d got=%b exp=%b", t, c, obs_a[c], exp_a[c]); end
            end
            total++; if (hit_count !== 16'(sat(exp_hits, 65535))) begin
                bad++; $display("FAIL random_hits t=%0d got=%0d exp=%0d", t, hit_count, exp_hits); end
            total++; if (miss_count !== 16'(sat(exp_miss, 65535))) begin
                bad++; $display("FAIL random_miss t=%0d got=%0d exp=%0d", t, miss_count, exp_miss); end
        end
    endtask

    task automatic test_saturate_and_clear();
        setup(120, STATIC, AUTO_HIT_WIDTH, 0, 0);
        for (int k = 0; k < 80; k++) vld_a[k] = 1'b1;
        run_trial(120);
        total++; if (s_hit_count !== 4'(sat(exp_hits, 15))) begin
            bad++; $display("FAIL saturate_small got=%0d exp=%0d", s_hit_count, sat(exp_hits, 15)); end
        total++; if (hit_count !== 16'(sat(exp_hits, 65535))) begin
            bad++; $display("FAIL saturate_wide got=%0d exp=%0d", hit_count, exp_hits); end
        setup(20, STATIC, AUTO_HIT_WIDTH, 1, 0);
        vld_a[2] = 1'b1;
        clr_a[4] = 1'b1;
        run_trial(20);
        total++; if (hit_count !== 16'(sat(exp_hits, 65535))) begin
            bad++; $display("FAIL clear_on_inc got=%0d exp=%0d", hit_count, exp_hits); end
        total++; if (s_hit_count !== 4'(sat(exp_hits, 15))) begin
            bad++; $display("FAIL clear_on_inc_small got=%0d exp=%0d", s_hit_count, exp_hits); end
    endtask

    task automatic test_reset_mid();
        setup(10, STATIC, AUTO_HIT_WIDTH, 2, 0);
        vld_a[1] = 1'b1;
        run_trial(10);
        @(posedge clk); #1;
        trigger_mode = STATIC; hitting_mode = AUTO_HIT_WIDTH; hit_width_cfg = 8'd8; trig_valid = 1'b1;
        @(posedge clk); #1; trig_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if (hit_out !== 1'b1) begin bad++; $display("FAIL mid_pre_hit got=%b exp=1", hit_out); end
        #2 rst_n = 1'b0;
        #1;
        exp_hits = 0; exp_miss = 0;
        total++; if ({trig_ready, busy, hit_out, bounce_ack} !== 4'b1000) begin
            bad++; $display("FAIL mid_reset_outputs got=%b exp=1000", {trig_ready, busy, hit_out, bounce_ack}); end
        total++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
            bad++; $display("FAIL mid_reset_counts got=%0d/%0d exp=0/0", hit_count, miss_count); end
        @(negedge clk) rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        total++; if ({trig_ready, busy, hit_out} !== 3'b100 || hit_count !== 16'd0) begin
            bad++; $display("FAIL mid_after_release got=%b cnt=%0d exp=100 cnt=0", {trig_ready, busy, hit_out}, hit_count); end
    endtask

    initial begin
        test_reset();
        test_auto();
        test_manual();
        test_timeout();
        test_glitch_and_held();
        test_back_to_back();
        test_random();
        test_saturate_and_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
